// File: rtl/bus_mem_responder_if.sv
// rtl/bus_mem_responder_if.sv - cpu0 bus and byte-loader signal bundle for bus_mem_responder
//
// Purpose: groups the CPU bus (address_bus, wr, tri-state data_bus) and the
// byte-serial loader handshake into one interface.
// Ports (per modport):
//   master - CPU/host side: drives address_bus, wr, ld_start, ld_valid,
//            ld_byte, ld_last; shares data_bus; observes ld_ready,
//            cpu_hold, ld_done, ld_count.
//   slave  - memory responder side: the mirror image of master.
interface bus_mem_responder_if #(
    parameter int ADDR_W = 8
);
    logic [15:0]     address_bus;
    logic            wr;
    wire  [15:0]     data_bus;
    logic            ld_start;
    logic            ld_valid;
    logic [7:0]      ld_byte;
    logic            ld_last;
    logic            ld_ready;
    logic            cpu_hold;
    logic            ld_done;
    logic [ADDR_W:0] ld_count;

    modport master (
        output address_bus, wr, ld_start, ld_valid, ld_byte, ld_last,
        inout  data_bus,
        input  ld_ready, cpu_hold, ld_done, ld_count
    );

    modport slave (
        input  address_bus, wr, ld_start, ld_valid, ld_byte, ld_last,
        inout  data_bus,
        output ld_ready, cpu_hold, ld_done, ld_count
    );
endinterface

// File: rtl/bus_mem_responder.sv
// rtl/bus_mem_responder.sv - cpu0 memory responder with byte-serial program loader
//
// Purpose: word-addressed 16-bit RAM answering cpu0 bus reads (zero latency)
// and writes, plus a loader that holds the CPU in reset while it assembles
// little-endian 16-bit words from a byte stream and commits them to RAM.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-low reset
//   bus   - bus_mem_responder_if.slave (CPU bus + loader handshake/status)
module bus_mem_responder #(
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    bus_mem_responder_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_LO,
        LOAD_HI,
        COMMIT,
        DONE
    } state_t;

    state_t            state;
    logic [15:0]       mem [DEPTH];
    logic [ADDR_W-1:0] ptr;
    logic [7:0]        lo;
    logic [7:0]        hi;
    logic              final_flag;
    logic              ready_q;
    logic              hold_q;
    logic              done_q;
    logic [ADDR_W:0]   count_q;

    logic              hit;
    logic [ADDR_W-1:0] idx;
    logic [15:0]       rd_data;

    assign hit     = (bus.address_bus[15:ADDR_W] == '0);
    assign idx     = bus.address_bus[ADDR_W-1:0];
    assign rd_data = hit ? mem[idx] : 16'h0000;

    // The bus is released whenever the CPU drives it or is held in reset.
    assign bus.data_bus = (!bus.wr && !hold_q) ? rd_data : 16'hzzzz;

    assign bus.ld_ready = ready_q;
    assign bus.cpu_hold = hold_q;
    assign bus.ld_done  = done_q;
    assign bus.ld_count = count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= '0;
            lo         <= '0;
            hi         <= '0;
            final_flag <= 1'b0;
            ready_q    <= 1'b0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.ld_start) begin
                        state   <= LOAD_LO;
                        ptr     <= '0;
                        count_q <= '0;
                        done_q  <= 1'b0;
                        hold_q  <= 1'b1;
                        ready_q <= 1'b1;
                    end
                end
                LOAD_LO: begin
                    if (bus.ld_valid) begin
                        lo <= bus.ld_byte;
                        if (bus.ld_last) begin
                            // Odd-length image: the last word is zero-padded.
                            hi         <= 8'h00;
                            final_flag <= 1'b1;
                            ready_q    <= 1'b0;
                            state      <= COMMIT;
                        end else begin
                            state <= LOAD_HI;
                        end
                    end
                end
                LOAD_HI: begin
                    if (bus.ld_valid) begin
                        hi         <= bus.ld_byte;
                        final_flag <= bus.ld_last;
                        ready_q    <= 1'b0;
                        state      <= COMMIT;
                    end
                end
                COMMIT: begin
                    count_q <= count_q + 1'b1;
                    // Saturate the pointer at the top word so it never wraps.
                    if (!(&ptr)) begin
                        ptr <= ptr + 1'b1;
                    end
                    if (final_flag || (&ptr)) begin
                        state  <= DONE;
                        hold_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        state   <= LOAD_LO;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                    hold_q  <= 1'b0;
                end
            endcase
        end
    end

    // Single write port: COMMIT only happens while cpu_hold is high, and the
    // CPU path is gated by cpu_hold, so the two sources never collide.
    always_ff @(posedge clk) begin
        if (state == COMMIT) begin
            mem[ptr] <= {hi, lo};
        end else if (bus.wr && hit && !hold_q) begin
            mem[idx] <= bus.data_bus;
        end
    end
endmodule

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
- Memory-side responder for the cpu0 system bus (address_bus, data_bus, wr). It serves CPU instruction/data reads and accepts CPU writes into a word-addressed RAM.
- A byte-serial loader port holds the CPU in reset while it assembles 16-bit program words and writes them into RAM.
- Sits between the cpu0 top and the board-level byte source (UART receiver / test host).

Parameters:
- ADDR_W, 8, RAM address width; DEPTH = 2**ADDR_W words of 16 bits.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-low reset (0 = reset).
- address_bus  input  16  CPU address.
- wr  input  1  CPU write strobe; 1 = CPU drives data_bus, 0 = read.
- data_bus  inout  16  shared CPU data bus.
- ld_start  input  1  one-cycle pulse that begins a load.
- ld_valid  input  1  byte-source valid.
- ld_byte  input  8  byte payload.
- ld_last  input  1  qualifies the final byte of the image, sampled with the byte.
- ld_ready  output  1  loader accepts a byte this cycle.
- cpu_hold  output  1  hold CPU in reset (OR'd into the CPU reset by the top level).
- ld_done  output  1  load finished; stays high until the next ld_start or reset.
- ld_count  output  ADDR_W+1  words committed in the current or last load.

Behaviour:
- Reset (reset=0, async): state IDLE; ld_ready=0, cpu_hold=0, ld_done=0, ld_count=0, load pointer=0. RAM contents are not cleared.
- Address decode: hit = (address_bus[15:ADDR_W]==0); index = address_bus[ADDR_W-1:0].
- CPU read: when wr=0 and cpu_hold=0, data_bus is driven combinationally (zero latency) with mem[index] on a hit, or 16'h0000 on a miss.
- data_bus is high-Z when wr=1 or cpu_hold=1.
- CPU write: on rising clk with wr=1, hit=1 and cpu_hold=0, mem[index] <= data_bus. Misses are ignored.
- State machine: IDLE, LOAD_LO, LOAD_HI, COMMIT, DONE.
  - IDLE/DONE: ld_start -> LOAD_LO. Clears pointer, ld_count and ld_done; sets cpu_hold=1. ld_start is ignored in every other state.
  - LOAD_LO: ld_ready=1. On ld_valid, lo <= ld_byte.
    - ld_last=1 -> hi <= 8'h00, go COMMIT with the final flag set.
    - Otherwise -> LOAD_HI.
  - LOAD_HI: ld_ready=1. On ld_valid, hi <= ld_byte; final flag <= ld_last; go COMMIT.
  - COMMIT (1 cycle, ld_ready=0): mem[pointer] <= {hi,lo}; pointer++; ld_count++.
    - Go DONE if the final flag is set or pointer was DEPTH-1. Otherwise go LOAD_LO.
  - DONE: cpu_hold=0, ld_done=1.
- Byte handshake: a transfer occurs only when ld_valid && ld_ready on a rising edge. ld_valid without ld_ready is held by the source (not dropped).
- Word ordering: low byte first, little-endian.
- Full condition: a commit to address DEPTH-1 ends the load even if ld_last was never seen. The pointer never wraps.
- cpu_hold is registered: it is 1 from the cycle after ld_start until DONE is entered.
- Reset mid-load: the partial word is discarded, words already committed remain in RAM, and the block returns to IDLE.
- CPU access during cpu_hold=1: reads are not driven and writes are ignored, so there is no RAM port conflict with COMMIT.
- RAM has one write port. Loader and CPU writes are mutually exclusive through cpu_hold.

Test Plan:
- Reset then idle: reset=0 -> ld_ready=0, cpu_hold=0, ld_done=0, ld_count=0. With wr=0 and address 0x0000 the bus is driven with mem[0] (preloaded 0x1234).
- Load 3 words: ld_start, then bytes 34 12 78 56 BC 9A with last on 9A.
  - mem[0..2] = 0x1234, 0x5678, 0x9ABC.
  - ld_count=3, ld_done=1, cpu_hold=0.
  - ld_ready is low during each COMMIT cycle.
- Odd final byte: ld_start, then bytes 11 22 33 with last on 33 -> mem[0]=0x2211, mem[1]=0x0033, ld_count=2.
- CPU access: wr=1, address 0x0005, data 0xBEEF, one clk -> then wr=0 reads 0xBEEF. wr=0 at address 0x0100 (miss) -> bus reads 0x0000, and a write to 0x0100 leaves the RAM unchanged.
- Hold isolation: during a load, wr=0 -> data_bus is Z. A wr=1 at 0x0005 with 0x0000 -> mem[5] is still 0xBEEF after the load.
- Full/abort:
  - Stream 2*DEPTH bytes with no last -> DONE after DEPTH words, ld_count=DEPTH, ld_ready=0 after that.
  - Separately, pulse reset after 5 bytes -> IDLE, mem[0..1] hold the two committed words, and the fifth byte is lost.
